// File: rtl/lcd_value_writer.sv
// lcd_value_writer: latches a 32-bit value, clears the display, converts the
// value to decimal with a sequential double-dabble, then streams the ASCII
// digits to the lcd controller one paced byte at a time.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start; value is latched on an accepted start
// CLEAR    | lcd_reset strobe cycle
// WAIT_CLR | display clear settling time (CLEAR_CYCLES)
// CONVERT  | 32 double-dabble steps, one per cycle
// SKIP     | walk the digit index past leading zeros (digit 0 is kept)
// EMIT     | lcd_write_en strobe carrying the current digit
// GAP      | pacing between writes (GAP_CYCLES)
// FINISH   | done strobe
module lcd_value_writer #(
  parameter int CLEAR_CYCLES   = 100000,
  parameter int GAP_CYCLES     = 100000,
  parameter bit SUPPRESS_ZEROS = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] value,
  output logic        lcd_write_en,
  output logic [7:0]  lcd_write_data,
  output logic        lcd_reset,
  output logic        busy,
  output logic        done
);

  localparam int MAX_CYC = (CLEAR_CYCLES > GAP_CYCLES) ? CLEAR_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 5) ? $clog2(MAX_CYC + 1) : 5;

  // A wait state always occupies at least one cycle, so a count of N is
  // realised by loading N-1 and leaving when the counter reaches zero.
  localparam logic [CNT_W-1:0] CLR_LOAD = (CLEAR_CYCLES > 0) ? CNT_W'(CLEAR_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNV_LOAD = CNT_W'(31);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WAIT_CLR, S_CONVERT, S_SKIP, S_EMIT, S_GAP, S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       bin_q, bin_d;
  logic [39:0]       bcd_q, bcd_d;
  logic [3:0]        idx_q, idx_d;
  logic              lcd_write_en_q, lcd_write_en_d;
  logic [7:0]        lcd_write_data_q, lcd_write_data_d;
  logic              lcd_reset_q, lcd_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [39:0]       bcd_adj;
  logic [3:0]        dig_q, dig_d;

  function automatic logic [3:0] digit_at(input logic [39:0] bcd, input logic [3:0] idx);
    logic [39:0] s;
    s = bcd >> {idx, 2'b00};
    return s[3:0];
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    idx_d   = idx_q;
    dig_q   = digit_at(bcd_q, idx_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d   = value;
          bcd_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d   = CLR_LOAD;
        state_d = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        if (cnt_q == '0) begin
          cnt_d   = CNV_LOAD;
          state_d = S_CONVERT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CONVERT: begin
        {bcd_d, bin_d} = {bcd_adj[38:0], bin_q, 1'b0};
        if (cnt_q == '0) begin
          idx_d   = 4'd9;
          state_d = S_SKIP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SKIP: begin
        if (SUPPRESS_ZEROS && dig_q == 4'd0 && idx_q != 4'd0) idx_d = idx_q - 4'd1;
        else                                                  state_d = S_EMIT;
      end
      S_EMIT: begin
        cnt_d   = GAP_LOAD;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          if (idx_q == 4'd0) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q - 4'd1;
            state_d = S_EMIT;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered,
    // aligned with the cycle the FSM spends in the corresponding state.
    dig_d            = digit_at(bcd_d, idx_d);
    lcd_reset_d      = (state_d == S_CLEAR);
    lcd_write_en_d   = (state_d == S_EMIT);
    lcd_write_data_d = lcd_write_en_d ? (8'h30 + {4'h0, dig_d}) : 8'h00;
    done_d           = (state_d == S_FINISH);
    busy_d           = (state_d != S_IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      bin_q            <= '0;
      bcd_q            <= '0;
      idx_q            <= '0;
      lcd_write_en_q   <= 1'b0;
      lcd_write_data_q <= 8'h00;
      lcd_reset_q      <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      bin_q            <= bin_d;
      bcd_q            <= bcd_d;
      idx_q            <= idx_d;
      lcd_write_en_q   <= lcd_write_en_d;
      lcd_write_data_q <= lcd_write_data_d;
      lcd_reset_q      <= lcd_reset_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign lcd_write_en   = lcd_write_en_q;
  assign lcd_write_data = lcd_write_data_q;
  assign lcd_reset      = lcd_reset_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
